dvsd_pe_seq: RTL and testbench

//  Registered, parametrised successor to the 8-bit combinational priority encoder.

---
 rtl/dvsd_pe_seq.sv | 154 +++++++++++++++
 tb/tb_dvsd_pe_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dvsd_pe_seq.sv
// -----------------------------------------------------------------------------
// dvsd_pe_seq
//
// Registered priority encoder with a sticky request register. Request lines are
// OR-ed into a pending vector while en=1. Each cycle one pending request is
// encoded and offered to a downstream consumer over a valid/ready handshake.
// Arbitration is either fixed priority (highest index wins) or descending
// round-robin. The en/eno/gs cascade signals of the original combinational
// encoder are kept so existing cascades still work.
//
// Parameters
//   WIDTH  number of request lines (>= 2)
//   OUT_W  encoded index width, must equal $clog2(WIDTH)
//   MODE   0 = fixed priority, 1 = round-robin
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         capture enable for in[]
//   in         request lines, OR-ed into pend while en=1
//   out        granted index (registered)
//   out_valid  out holds a grant
//   out_ready  consumer accepts the grant when out_valid & out_ready
//   gs         group select: something is pending or being offered
//   eno        cascade enable out: enabled, no new, pending or offered request
//   pend       pending request vector (registered)
// -----------------------------------------------------------------------------
module dvsd_pe_seq #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 3,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gs,
  output logic             eno,
  output logic [WIDTH-1:0] pend
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pend_reg,  pend_next;
  logic [OUT_W-1:0] out_reg,   out_next;
  logic             valid_reg, valid_next;
  // Round-robin search start; the next search begins at this index and walks
  // downwards, wrapping from 0 to WIDTH-1.
  logic [OUT_W-1:0] ptr_reg,   ptr_next;

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] le_mask;     // bits whose index is <= ptr_reg
  logic [WIDTH-1:0] rr_masked;   // pending bits at or below the pointer
  logic [OUT_W-1:0] fp_sel;      // highest pending index overall
  logic [OUT_W-1:0] rr_sel;      // round-robin choice
  logic [OUT_W-1:0] sel;
  logic             load;
  logic [WIDTH-1:0] clr;

  // Highest set bit of a vector; returns 0 for an empty vector (callers only
  // use the result when the vector is non-zero).
  function automatic logic [OUT_W-1:0] hi_idx(input logic [WIDTH-1:0] v);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = OUT_W'(i);
      end
    end
    return idx;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign le_mask[gi] = (OUT_W'(gi) <= ptr_reg);
    end
  endgenerate

  // Descending wrap-around search from ptr: the first hit among indices
  // ptr..0 is the highest pending bit at or below ptr. If none exist, the
  // search wraps to WIDTH-1 and the first hit is simply the highest pending
  // bit overall. With ptr = WIDTH-1 (after reset) this equals fixed priority.
  always_comb begin
    fp_sel    = hi_idx(pend_reg);
    rr_masked = pend_reg & le_mask;
    rr_sel    = (rr_masked != '0) ? hi_idx(rr_masked) : fp_sel;
    sel       = (MODE == 1) ? rr_sel : fp_sel;
  end

  // A new grant can be placed whenever the output slot is empty or is being
  // emptied this cycle, and something is pending.
  assign load = (~valid_reg | out_ready) & (pend_reg != '0);

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_clr
      assign clr[gi] = load & (sel == OUT_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    out_next   = out_reg;
    valid_next = valid_reg;
    ptr_next   = ptr_reg;

    if (load) begin
      out_next   = sel;
      valid_next = 1'b1;
      ptr_next   = (sel == '0) ? OUT_W'(WIDTH - 1) : sel - OUT_W'(1);
    end else if (out_ready) begin
      valid_next = 1'b0;
    end

    // Set after clear: a request arriving on the bit being granted this cycle
    // stays pending for a later grant.
    pend_next = (pend_reg & ~clr) | (en ? in : '0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      ptr_reg   <= OUT_W'(WIDTH - 1);
    end else begin
      pend_reg  <= pend_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      ptr_reg   <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign pend      = pend_reg;
  assign gs        = (pend_reg != '0) | valid_reg;
  assign eno       = en & (in == '0) & (pend_reg == '0) & ~valid_reg;

endmodule

// File: tb/tb_dvsd_pe_seq.sv
// -----------------------------------------------------------------------------
// tb_dvsd_pe_seq
//
// Two instances (fixed priority and round-robin) share one stimulus. A table of
// per-cycle vectors drives both and checks the fixed-priority instance; short
// hand-written sequences then cover reset-after-grant and round-robin
// alternation for both instances.
// -----------------------------------------------------------------------------
module tb_dvsd_pe_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic       out_ready;

  logic [2:0] out0,  out1;
  logic       valid0, valid1;
  logic       gs0,   gs1;
  logic       eno0,  eno1;
  logic [7:0] pend0, pend1;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dvsd_pe_seq #(.WIDTH(8), .OUT_W(3), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out0), .out_valid(valid0), .out_ready(out_ready),
    .gs(gs0), .eno(eno0), .pend(pend0)
  );

  dvsd_pe_seq #(.WIDTH(8), .OUT_W(3), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out1), .out_valid(valid1), .out_ready(out_ready),
    .gs(gs1), .eno(eno1), .pend(pend1)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic       rdy;
    logic [2:0] out;
    logic       valid;
    logic [7:0] pend;
    logic       gs;
    logic       eno;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs, then let one rising edge pass and settle.
  task automatic step(input logic r, input logic e, input logic [7:0] i, input logic rd);
    rst       = r;
    en        = e;
    in        = i;
    out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rst   en    in     rdy   out   v     pend   gs    eno
    // reset, then a single request on bit 0
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    // A5 drains as 7,5,2,0 one per cycle
    tbl[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd7, 1'b1, 8'h25, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd5, 1'b1, 8'h05, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd2, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    // backpressure: 7 granted and held, 0 waits in pend
    tbl[10] = '{1'b0, 1'b1, 8'h80, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h01, 1'b0, 3'd7, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd7, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    // set wins over clear on the bit being granted
    tbl[15] = '{1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    // en=0 blocks capture entirely
    tbl[19] = '{1'b0, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    // reset in the middle of a stalled handshake
    tbl[21] = '{1'b0, 1'b1, 8'hF0, 1'b0, 3'd0, 1'b0, 8'hF0, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 8'hF0, 1'b0, 3'd7, 1'b1, 8'hF0, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; in = 8'h00; out_ready = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].in, tbl[i].rdy);
      $display("vec %0d: rst=%0b en=%0b in=%02h rdy=%0b -> out=%0d v=%0b pend=%02h gs=%0b eno=%0b",
               i, tbl[i].rst, tbl[i].en, tbl[i].in, tbl[i].rdy, out0, valid0, pend0, gs0, eno0);
      chk($sformatf("v%0d.out", i),   32'(out0),   32'(tbl[i].out));
      chk($sformatf("v%0d.valid", i), 32'(valid0), 32'(tbl[i].valid));
      chk($sformatf("v%0d.pend", i),  32'(pend0),  32'(tbl[i].pend));
      chk($sformatf("v%0d.gs", i),    32'(gs0),    32'(tbl[i].gs));
      chk($sformatf("v%0d.eno", i),   32'(eno0),   32'(tbl[i].eno));
    end

    // Round-robin instance was also reset by the last vector.
    chk("rr.rst.valid", 32'(valid1), 32'd0);
    chk("rr.rst.pend",  32'(pend1),  32'd0);
    chk("rr.rst.out",   32'(out1),   32'd0);

    // First round-robin grant after reset is the highest pending bit.
    step(1'b0, 1'b1, 8'h24, 1'b1);
    chk("rr.cap.pend", 32'(pend1), 32'h24);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    $display("first grant after reset: rr out=%0d fp out=%0d", out1, out0);
    chk("rr.first.out",   32'(out1),   32'd5);
    chk("rr.first.valid", 32'(valid1), 32'd1);
    chk("fp.first.out",   32'(out0),   32'd5);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rr.second.out", 32'(out1), 32'd2);
    chk("rr.second.pend", 32'(pend1), 32'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rr.idle.valid", 32'(valid1), 32'd0);

    // Held 8'h81: round-robin alternates 7,0,... while fixed priority starves 0.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h81, 1'b1);
    chk("alt.cap.pend0", 32'(pend0), 32'h81);
    chk("alt.cap.pend1", 32'(pend1), 32'h81);
    begin
      logic [2:0] exp_rr [4];
      exp_rr[0] = 3'd7; exp_rr[1] = 3'd0; exp_rr[2] = 3'd7; exp_rr[3] = 3'd0;
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 1'b1, 8'h81, 1'b1);
        $display("alt %0d: rr out=%0d fp out=%0d pend=%02h/%02h", k, out1, out0, pend1, pend0);
        chk($sformatf("alt%0d.rr.out", k),   32'(out1),   32'(exp_rr[k]));
        chk($sformatf("alt%0d.rr.valid", k), 32'(valid1), 32'd1);
        chk($sformatf("alt%0d.rr.pend", k),  32'(pend1),  32'h81);
        chk($sformatf("alt%0d.fp.out", k),   32'(out0),   32'd7);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
